cfg_stream_loader: RTL and testbench
====================================

# cfg_stream_loader

Configuration sequencer for a CGRA tile. It accepts a stream of (address, data) configuration words from an upstream source over a valid/ready handshake and drives the tile's configuration bus (config_addr / config_data), one word at a time, holding each word for a programmable number of cycles. It reports busy/done/error status to the system controller. It sits between the configuration source (bitstream FIFO or host interface) and `top.config_addr_in` / `top.config_data_in`.

## Interface
- ADDR_W, 32, config address width
- DATA_W, 32, config data width
- HOLD_CYCLES, 1, cycles each word is held on the bus; legal range is 1 to 15
- CNT_W, 16, width of the written-word counter
- clk_in  input  1  clock
- reset_in  input  1  reset; asynchronous and active-high
- start_in  input  1  single-cycle pulse that begins a load session
- s_valid_in  input  1  upstream word valid
- s_ready_out  output  1  loader can accept a word
- s_addr_in  input  ADDR_W  word address
- s_data_in  input  DATA_W  word data
- s_last_in  input  1  marks the final word of the session
- config_addr_out  output  ADDR_W  tile config address; 0 when idle
- config_data_out  output  DATA_W  tile config data; 0 when idle
- config_we_out  output  1  high while a word is on the bus
- busy_out  output  1  session in progress
- done_out  output  1  session completed; sticky until the next start
- err_out  output  1  sticky error flag
- word_count_out  output  CNT_W  number of words written this session

## Operation
- FSM has four states: IDLE, WAIT, WRITE, DONE.
- IDLE: start_in moves the FSM to WAIT. It also clears word_count_out, err_out and done_out.
- WAIT:
  - s_ready_out=1.
  - On a handshake (s_valid_in & s_ready_out), the word is latched and the FSM moves to WRITE.
  - A word with s_addr_in==0 is dropped, because address 0 is the bus no-op. This sets err_out. The FSM stays in WAIT, or goes to DONE if that word carried last.
- WRITE:
  - Drives the latched addr/data with config_we_out=1 for exactly HOLD_CYCLES cycles.
  - Increments word_count_out once per word. The counter saturates at all-ones.
  - Afterwards the FSM goes to DONE if the latched last bit was set, otherwise back to WAIT.
- DONE: done_out=1 and busy_out=0. start_in re-enters WAIT with cleared status.
- busy_out=1 in WAIT and WRITE.
- start_in is ignored in WAIT and WRITE.
- s_ready_out=0 in every state except WAIT.
- Outside WRITE, config_addr_out and config_data_out are 0 and config_we_out is 0.
- Reset values (asserted mid-session, the FSM aborts immediately to IDLE):
  - every output is 0;
  - the latched word is discarded;
  - the counter is cleared.

## Timing
- A handshake at edge N puts the word on the bus in cycles N+1 through N+HOLD_CYCLES.
- s_ready_out returns high in the cycle after the final hold cycle.
- Throughput is one word per HOLD_CYCLES+1 cycles.
- done_out rises in the cycle after the last word's final hold cycle.
- A start_in pulse at edge N gives busy_out=1 and s_ready_out=1 from cycle N+1.
- s_valid_in high during the start_in cycle is not accepted. The first acceptance is at the next edge.
- Upstream may hold s_valid_in and change data while s_ready_out=0. Only the values present at the handshake edge are used.

## Configuration
- Macro: CFG_LOADER_CHECKSUM_EN.
- When defined:
  - The word flagged s_last_in is a trailer and is not written to the bus.
  - Its data is compared with the XOR of all data values written this session.
  - On mismatch, err_out is set.
  - The FSM moves from WAIT directly to DONE on the trailer handshake.
  - The trailer's address is ignored and is not checked for 0.
  - The trailer is not counted.
- When undefined: the last word is written and counted like any other, and no checksum logic is synthesized.

## Test plan
- Reset release, no start -> all outputs stay 0, s_ready_out=0 indefinitely.
- HOLD_CYCLES=1, start, 3 words (0x10/0xA, 0x20/0xB, 0x30/0xC with last), source always valid -> each word appears for 1 cycle with config_we_out=1, words spaced 2 cycles apart, word_count_out=3, done_out=1, err_out=0.
- HOLD_CYCLES=3, 2 words with a source stall of 5 cycles between them -> each word is held 3 cycles, bus is 0 while waiting, done_out=1 after the second word.
- Word with addr 0 mid-stream -> it is not driven on the bus, err_out=1 sticky, word_count_out excludes it, later words still written.
- reset_in asserted during WRITE of the 2nd of 4 words -> all outputs 0 asynchronously. A new start then reloads from word count 0.
- With CFG_LOADER_CHECKSUM_EN: data 0x5, 0x3, then a trailer of 0x6 -> 2 writes, err_out=0. Repeat with a trailer of 0x7 -> err_out=1, done_out=1.

Source files
------------

// File: rtl/cfg_stream_loader.sv
// Configuration sequencer: takes (addr, data) words over valid/ready and drives the tile config bus.
// Optional trailer checksum checking is enabled by defining CFG_LOADER_CHECKSUM_EN.
module cfg_stream_loader #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              start_in,
  input  logic              s_valid_in,
  output logic              s_ready_out,
  input  logic [ADDR_W-1:0] s_addr_in,
  input  logic [DATA_W-1:0] s_data_in,
  input  logic              s_last_in,
  output logic [ADDR_W-1:0] config_addr_out,
  output logic [DATA_W-1:0] config_data_out,
  output logic              config_we_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out,
  output logic [CNT_W-1:0]  word_count_out
);

  typedef enum logic [1:0] {StIdle, StWait, StWrite, StDone} state_e;

  localparam logic [3:0] HoldLast = 4'(HOLD_CYCLES - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               last_q, last_d;
  logic [3:0]         hold_q, hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               hs;
`ifdef CFG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]  xor_q, xor_d;
`endif

  assign hs = s_valid_in && (state_q == StWait);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef CFG_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start_in) begin
          state_d = StWait;
          cnt_d   = '0;
          err_d   = 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      StWait: begin
        if (hs) begin
`ifdef CFG_LOADER_CHECKSUM_EN
          // Trailer carries the expected XOR of the session's written data.
          if (s_last_in) begin
            state_d = StDone;
            if (s_data_in != xor_q) err_d = 1'b1;
          end else
`endif
          if (s_addr_in == '0) begin
            err_d = 1'b1;
            if (s_last_in) state_d = StDone;
          end else begin
            addr_d  = s_addr_in;
            data_d  = s_data_in;
            last_d  = s_last_in;
            hold_d  = '0;
            state_d = StWrite;
`ifdef CFG_LOADER_CHECKSUM_EN
            xor_d   = xor_q ^ s_data_in;
`endif
          end
        end
      end
      StWrite: begin
        if (hold_q == HoldLast) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d = last_q ? StDone : StWait;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      hold_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef CFG_LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef CFG_LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign s_ready_out     = (state_q == StWait);
  assign busy_out        = (state_q == StWait) || (state_q == StWrite);
  assign config_we_out   = (state_q == StWrite);
  assign config_addr_out = config_we_out ? addr_q : '0;
  assign config_data_out = config_we_out ? data_q : '0;
  assign done_out        = (state_q == StDone);
  assign err_out         = err_q;
  assign word_count_out  = cnt_q;

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Bench for cfg_stream_loader: two instances (hold 1 and hold 3) checked every cycle against a
// transaction-level model, plus directed scenarios with literal expectations.
module tb_cfg_stream_loader;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;
`ifdef CFG_LOADER_CHECKSUM_EN
  localparam bit Ck = 1'b1;
`else
  localparam bit Ck = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic          start[2], valid[2], last[2];
  logic [AW-1:0] addr[2];
  logic [DW-1:0] data[2];
  logic          ready[2], we[2], busy[2], done[2], err[2];
  logic [AW-1:0] caddr[2];
  logic [DW-1:0] cdata[2];
  logic [CW-1:0] cnt[2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int we_cnt[2];
  int acc_cyc[2];
  int hold_of[2] = '{1, 3};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cfg_stream_loader #(
      .ADDR_W(AW), .DATA_W(DW), .HOLD_CYCLES((g == 0) ? 1 : 3), .CNT_W(CW)
    ) u_dut (
      .clk_in(clk), .reset_in(rst), .start_in(start[g]),
      .s_valid_in(valid[g]), .s_ready_out(ready[g]), .s_addr_in(addr[g]),
      .s_data_in(data[g]), .s_last_in(last[g]),
      .config_addr_out(caddr[g]), .config_data_out(cdata[g]), .config_we_out(we[g]),
      .busy_out(busy[g]), .done_out(done[g]), .err_out(err[g]), .word_count_out(cnt[g])
    );
  end

  // Model: a session flag, remaining bus cycles of the current word, and status bits.
  bit            m_sess[2], m_done[2], m_err[2], m_acc[2], m_last[2];
  int            m_left[2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_data[2];
  logic [CW-1:0] m_cnt[2];
  logic [DW-1:0] m_xor[2];

  task automatic mclear(input int k);
    m_sess[k] = 0; m_done[k] = 0; m_err[k] = 0; m_acc[k] = 0; m_last[k] = 0;
    m_left[k] = 0; m_addr[k] = '0; m_data[k] = '0; m_cnt[k] = '0; m_xor[k] = '0;
  endtask

  task automatic mstep(input int k);
    m_acc[k] = 0;
    if (m_left[k] > 0) begin
      m_left[k]--;
      if (m_left[k] == 0) begin
        if (m_cnt[k] != '1) m_cnt[k]++;
        if (m_last[k]) begin m_sess[k] = 0; m_done[k] = 1; end
      end
    end else if (m_sess[k]) begin
      if (valid[k]) begin
        m_acc[k] = 1;
        if (Ck && last[k]) begin
          if (data[k] != m_xor[k]) m_err[k] = 1;
          m_sess[k] = 0; m_done[k] = 1;
        end else if (addr[k] == 0) begin
          m_err[k] = 1;
          if (last[k]) begin m_sess[k] = 0; m_done[k] = 1; end
        end else begin
          m_addr[k] = addr[k]; m_data[k] = data[k]; m_last[k] = last[k];
          m_left[k] = hold_of[k];
          m_xor[k] = m_xor[k] ^ data[k];
        end
      end
    end else if (start[k]) begin
      m_sess[k] = 1; m_done[k] = 0; m_cnt[k] = '0; m_err[k] = 0; m_xor[k] = '0;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) mclear(k);
      else mstep(k);
    end
  end

  function automatic logic [84:0] expv(input int k);
    logic w;
    w = m_left[k] > 0;
    return {m_sess[k] && m_left[k] == 0, m_sess[k], w, m_done[k], m_err[k],
            w ? m_addr[k] : AW'(0), w ? m_data[k] : DW'(0), m_cnt[k]};
  endfunction

  function automatic logic [84:0] dutv(input int k);
    return {ready[k], busy[k], we[k], done[k], err[k], caddr[k], cdata[k], cnt[k]};
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (dutv(k) !== expv(k)) begin
        n_bad++;
        $display("FAIL cycle%0d_dut%0d got=%h exp=%h", cyc, k, dutv(k), expv(k));
      end
      if (we[k]) we_cnt[k]++;
    end
  end

  task automatic check(input string nm, input logic [84:0] got, input logic [84:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in(input int k);
    start[k] = 0; valid[k] = 0; last[k] = 0; addr[k] = '0; data[k] = '0;
  endtask

  task automatic wait_cycles(input int k, input int n);
    idle_in(k);
    repeat (n) tick();
  endtask

  // Valid is held with a junk word during the start cycle; it must not be taken.
  task automatic do_start(input int k);
    start[k] = 1; valid[k] = 1; addr[k] = 'h99; data[k] = 'h99; last[k] = 1;
    tick();
    start[k] = 0;
    check($sformatf("start_dut%0d", k), {busy[k], ready[k], cnt[k]}, {2'b11, CW'(0)});
    we_cnt[k] = 0;
  endtask

  // Keeps valid high; junk is shown while the model says the loader cannot accept.
  task automatic send(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic l);
    int n = 0;
    do begin
      valid[k] = 1;
      if (m_sess[k] && m_left[k] == 0) begin
        addr[k] = a; data[k] = d; last[k] = l;
      end else begin
        addr[k] = $urandom; data[k] = $urandom; last[k] = $urandom_range(0, 1) == 1;
      end
      tick();
      n++;
    end while (!m_acc[k] && n < 100);
    acc_cyc[k] = cyc;
    if (!m_acc[k]) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout_dut%0d got=no_accept exp=accept", k);
    end
    valid[k] = 0;
  endtask

  task automatic async_reset();
    #2 rst = 1;
    mclear(0); mclear(1);
    #1;
    check("async_rst_dut0", dutv(0), '0);
    check("async_rst_dut1", dutv(1), '0);
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    int t1;
    mclear(0); mclear(1);
    idle_in(0); idle_in(1);
    we_cnt[0] = 0; we_cnt[1] = 0;
    repeat (3) tick();
    rst = 0;
    repeat (8) tick();
    check("no_start_dut0", dutv(0), '0);
    check("no_start_dut1", dutv(1), '0);

    // Hold 1, three words, source always valid.
    do_start(0);
    send(0, 'h10, 'hA, 0); t1 = acc_cyc[0];
    send(0, 'h20, 'hB, 0);
    check("h1_spacing", 85'(acc_cyc[0] - t1), 85'(2));
    send(0, 'h30, 'hC, 1);
    wait_cycles(0, 3);
    check("h1_count", cnt[0], Ck ? 2 : 3);
    check("h1_we_cycles", 85'(we_cnt[0]), Ck ? 2 : 3);
    check("h1_done_err", {done[0], err[0], busy[0]}, Ck ? 3'b110 : 3'b100);

    // Hold 3, two words with a 5-cycle source stall.
    do_start(1);
    send(1, 'h40, 'h1, 0);
    wait_cycles(1, 5);
    send(1, 'h50, 'h2, 1);
    wait_cycles(1, 5);
    check("h3_count", cnt[1], Ck ? 1 : 2);
    check("h3_we_cycles", 85'(we_cnt[1]), Ck ? 3 : 6);
    check("h3_done_err", {done[1], err[1]}, Ck ? 2'b11 : 2'b10);

    // Address 0 in mid-stream is dropped and flags an error.
    do_start(0);
    send(0, 'h11, 'h1, 0);
    send(0, 'h0, 'h2, 0);
    check("addr0_err", err[0], 1);
    send(0, 'h12, 'h3, 1);
    wait_cycles(0, 3);
    check("addr0_count", cnt[0], Ck ? 1 : 2);
    check("addr0_done_err", {done[0], err[0]}, 2'b11);

    // Reset during the second word's write, then a fresh session.
    do_start(1);
    send(1, 'h21, 'h1, 0);
    send(1, 'h22, 'h2, 0);
    check("mid_write_we", {we[1], caddr[1]}, {1'b1, AW'('h22)});
    async_reset();
    do_start(1);
    send(1, 'h31, 'h1, 0);
    send(1, 'h32, 'h2, 0);
    send(1, 'h33, 'h4, 0);
    send(1, 'h34, 'h7, 1);
    wait_cycles(1, 5);
    check("reload_count", cnt[1], Ck ? 3 : 4);
    check("reload_done_err", {done[1], err[1]}, 2'b10);

    // Checksum trailer: good then bad.
    do_start(0);
    send(0, 'h1, 'h5, 0);
    send(0, 'h2, 'h3, 0);
    send(0, 'h3, 'h6, 1);
    wait_cycles(0, 3);
    check("ck_good_count", cnt[0], Ck ? 2 : 3);
    check("ck_good_err", {done[0], err[0]}, 2'b10);
    do_start(0);
    send(0, 'h1, 'h5, 0);
    send(0, 'h2, 'h3, 0);
    send(0, 'h3, 'h7, 1);
    wait_cycles(0, 3);
    check("ck_bad_err", {done[0], err[0]}, Ck ? 2'b11 : 2'b10);

    // Random traffic on both instances, with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        start[k] = $urandom_range(0, 19) == 0;
        valid[k] = $urandom_range(0, 9) < 6;
        addr[k]  = $urandom_range(0, 7);
        data[k]  = $urandom;
        last[k]  = $urandom_range(0, 4) == 0;
      end
      if ($urandom_range(0, 499) == 0) async_reset();
      else tick();
    end
    idle_in(0); idle_in(1);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
